// File: rtl/ddr_pkg.sv
// Shared DDR command-bus definitions: decoded command set, bank-table entry and pin encodings.
// Used by the responder model and the controller's command block.
package ddr_pkg;

    typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, PREA, REF, MRS} cmd_t;

    localparam int ROW_W_MAX = 17;

    typedef struct packed {
        logic                 open;
        logic [ROW_W_MAX-1:0] row;
    } bank_entry_t;

    // {act_n, ras_n, cas_n, we_n} with cs_n=0; ACT is identified by act_n alone
    localparam logic       ENC_ACT_N = 1'b0;
    localparam logic [3:0] ENC_RD    = 4'b1101;
    localparam logic [3:0] ENC_WR    = 4'b1100;
    localparam logic [3:0] ENC_PRE   = 4'b1010;
    localparam logic [3:0] ENC_REF   = 4'b1001;
    localparam logic [3:0] ENC_MRS   = 4'b1000;
    localparam logic [3:0] ENC_NOP   = 4'b1111;

    // Two data windows of equal length, given by start offsets from a common reference edge.
    function automatic logic windows_overlap(input int a_start, input int b_start, input int len);
        return (a_start < b_start + len) && (b_start < a_start + len);
    endfunction

endpackage

// File: rtl/ddr_cmd_decode.sv
// Combinational decode of the DDR command pins into a cmd_t.
// A10 distinguishes PREA from PRE; reserved encodings decode as NOP.
module ddr_cmd_decode
    import ddr_pkg::*;
(
    input  logic cs_n,
    input  logic act_n,
    input  logic ras_n,
    input  logic cas_n,
    input  logic we_n,
    input  logic a10,
    output cmd_t cmd
);

    always_comb begin
        cmd = NOP;
        if (!cs_n) begin
            if (act_n == ENC_ACT_N) begin
                cmd = ACT;
            end else begin
                case ({act_n, ras_n, cas_n, we_n})
                    ENC_RD:  cmd = RD;
                    ENC_WR:  cmd = WR;
                    ENC_PRE: cmd = a10 ? PREA : PRE;
                    ENC_REF: cmd = REF;
                    ENC_MRS: cmd = MRS;
                    ENC_NOP: cmd = NOP;
                    default: cmd = NOP;
                endcase
            end
        end
    end

endmodule

// File: rtl/ddr_dram_responder.sv
// DRAM-side responder: tracks open rows per bank, returns read bursts CL cycles after RD and
// absorbs write bursts CWL cycles after WR, flagging protocol violations in sticky error bits.
module ddr_dram_responder
    import ddr_pkg::*;
#(
    parameter int BG_W      = 2,
    parameter int BA_W      = 2,
    parameter int ROW_W     = 17,
    parameter int DQ_W      = 8,
    parameter int BL        = 8,
    parameter int CL        = 11,
    parameter int CWL       = 9,
    parameter int MEM_IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             act_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [BG_W-1:0]  bg,
    input  logic [BA_W-1:0]  ba,
    input  logic [ROW_W-1:0] addr,
    input  logic [DQ_W-1:0]  dq_in,
    output logic [DQ_W-1:0]  dq_out,
    output logic             dq_oe,
    output logic             err_state,
    output logic             err_burst,
    output logic             mr_seen
);

    localparam int BANK_W     = BG_W + BA_W;
    localparam int NBANK      = 2 ** BANK_W;
    localparam int RD_DEPTH   = CL + BL;
    localparam int WR_DEPTH   = CWL + BL;
    localparam int IDX_FULL_W = BANK_W + ROW_W_MAX + 7;

    typedef struct packed {
        logic                 valid;
        logic [MEM_IDX_W-1:0] idx;
    } slot_t;

    cmd_t                   cmd;
    bank_entry_t            banks [NBANK];
    bank_entry_t            sel;
    logic [BANK_W-1:0]      bank_sel;
    logic                   any_open;
    logic                   rd_conflict;
    logic                   wr_conflict;
    logic [IDX_FULL_W-1:0]  idx_full;
    logic [MEM_IDX_W-1:0]   new_idx;
    slot_t                  rpipe [RD_DEPTH];
    slot_t                  wpipe [WR_DEPTH];
    logic [DQ_W-1:0]        wbuf  [BL];
    logic [BL*DQ_W-1:0]     wword;
    logic [BL*DQ_W-1:0]     mem   [2**MEM_IDX_W];
    logic                   unused_bits;

    ddr_cmd_decode u_cmd_decode (
        .cs_n  (cs_n),
        .act_n (act_n),
        .ras_n (ras_n),
        .cas_n (cas_n),
        .we_n  (we_n),
        .a10   (addr[10]),
        .cmd   (cmd)
    );

    assign bank_sel    = {bg, ba};
    assign sel         = banks[bank_sel];
    assign idx_full    = {bank_sel, sel.row, addr[9:3]};
    assign new_idx     = idx_full[MEM_IDX_W-1:0];
    // Column bits below the burst boundary and high index bits never address storage
    assign unused_bits = ^{addr[2:0], idx_full};

    always_comb begin
        any_open = 1'b0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (banks[b].open) any_open = 1'b1;
        end
    end

    // Slot k holds a command sampled k+1 edges ago; windows are compared as offsets from now.
    always_comb begin
        rd_conflict = 1'b0;
        wr_conflict = 1'b0;
        for (int unsigned k = 0; k < RD_DEPTH; k++) begin
            if (rpipe[k].valid) begin
                if (k < BL - 1) rd_conflict = 1'b1;
                if (windows_overlap(CWL, CL - int'(k) - 1, BL)) wr_conflict = 1'b1;
            end
        end
        for (int unsigned k = 0; k < WR_DEPTH; k++) begin
            if (wpipe[k].valid) begin
                if (k < BL - 1) wr_conflict = 1'b1;
                if (windows_overlap(CL, CWL - int'(k) - 1, BL)) rd_conflict = 1'b1;
            end
        end
    end

    always_comb begin
        wword = '0;
        for (int unsigned i = 0; i < BL; i++) begin
            wword[i*DQ_W +: DQ_W] = wbuf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NBANK; b++) banks[b] <= '0;
            for (int unsigned k = 0; k < RD_DEPTH; k++) rpipe[k] <= '0;
            for (int unsigned k = 0; k < WR_DEPTH; k++) wpipe[k] <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            err_state <= 1'b0;
            err_burst <= 1'b0;
            mr_seen   <= 1'b0;
        end else begin
            rpipe[0] <= '0;
            wpipe[0] <= '0;
            for (int unsigned k = 1; k < RD_DEPTH; k++) rpipe[k] <= rpipe[k-1];
            for (int unsigned k = 1; k < WR_DEPTH; k++) wpipe[k] <= wpipe[k-1];

            dq_oe  <= 1'b0;
            dq_out <= '0;
            for (int unsigned i = 0; i < BL; i++) begin
                if (rpipe[CL-1+i].valid) begin
                    dq_oe  <= 1'b1;
                    dq_out <= mem[rpipe[CL-1+i].idx][i*DQ_W +: DQ_W];
                end
            end

            // Rejected RD/WR never enter a pipeline and never auto-precharge.
            case (cmd)
                ACT: begin
                    if (sel.open) err_state <= 1'b1;
                    banks[bank_sel] <= '{open: 1'b1, row: ROW_W_MAX'(addr)};
                end
                RD: begin
                    if (!sel.open) begin
                        err_state <= 1'b1;
                    end else if (rd_conflict) begin
                        err_burst <= 1'b1;
                    end else begin
                        rpipe[0] <= '{valid: 1'b1, idx: new_idx};
                        if (addr[10]) banks[bank_sel].open <= 1'b0;
                    end
                end
                WR: begin
                    if (!sel.open) begin
                        err_state <= 1'b1;
                    end else if (wr_conflict) begin
                        err_burst <= 1'b1;
                    end else begin
                        wpipe[0] <= '{valid: 1'b1, idx: new_idx};
                        if (addr[10]) banks[bank_sel].open <= 1'b0;
                    end
                end
                PRE:  banks[bank_sel].open <= 1'b0;
                PREA: for (int unsigned b = 0; b < NBANK; b++) banks[b].open <= 1'b0;
                REF:  if (any_open) err_state <= 1'b1;
                MRS:  mr_seen <= 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; a commit on the reset edge itself is suppressed so rst aborts writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BL; i++) begin
                if (wpipe[CWL-1+i].valid) wbuf[i] <= dq_in;
            end
            if (wpipe[WR_DEPTH-1].valid) mem[wpipe[WR_DEPTH-1].idx] <= wword;
        end
    end

endmodule

// File: tb/tb_ddr_dram_responder.sv
// Scoreboard bench for ddr_dram_responder: expected read beats are queued with their due cycle
// when RD is issued and compared as the responder drives them.
module tb_ddr_dram_responder;

    localparam int CL  = 11;
    localparam int CWL = 9;
    localparam int BL  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, act_n, ras_n, cas_n, we_n;
    logic [1:0]  bg, ba;
    logic [16:0] addr;
    logic [7:0]  dq_in = '0;
    logic [7:0]  dq_out;
    logic        dq_oe, err_state, err_burst, mr_seen;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } beat_t;

    beat_t sbq[$];
    beat_t wq[$];
    beat_t wb;
    beat_t mb;

    ddr_dram_responder #(
        .BG_W(2), .BA_W(2), .ROW_W(17), .DQ_W(8), .BL(BL), .CL(CL), .CWL(CWL), .MEM_IDX_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .bg        (bg),
        .ba        (ba),
        .addr      (addr),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .err_state (err_state),
        .err_burst (err_burst),
        .mr_seen   (mr_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        return (kind == 0) ? 8'(8'h11 * (i + 1)) : 8'(8'hA0 + i);
    endfunction

    // Write data: driven so the beat due at cycle c is sampled on the edge that starts cycle c.
    always @(posedge clk) begin
        #1;
        if (wq.size() > 0 && wq[0].cyc == cyc + 1) begin
            wb    = wq.pop_front();
            dq_in = wb.data;
        end else begin
            dq_in = '0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                mb = sbq.pop_front();
                check("rd_cycle", cyc, mb.cyc);
                check("rd_oe", dq_oe, 1'b1);
                check("rd_data", dq_out, mb.data);
            end else if (dq_oe) begin
                check("spurious_oe", dq_oe, 1'b0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one command for one cycle; t is the cycle number of its sampling edge.
    task automatic issue(input logic an, input logic r, input logic c, input logic w,
                         input logic [1:0] g, input logic [1:0] b, input logic [16:0] a,
                         output int t);
        cs_n = 1'b0; act_n = an; ras_n = r; cas_n = c; we_n = w;
        bg = g; ba = b; addr = a;
        t = cyc + 1;
        @(posedge clk);
        #1;
        cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic act(input logic [1:0] g, input logic [1:0] b, input logic [16:0] row);
        int t;
        issue(1'b0, row[16], row[15], row[14], g, b, row, t);
    endtask

    task automatic rd(input logic [1:0] g, input logic [1:0] b, input logic [9:0] col,
                      input logic a10, output int t);
        issue(1'b1, 1'b1, 1'b0, 1'b1, g, b, {6'b0, a10, col}, t);
    endtask

    task automatic wr(input logic [1:0] g, input logic [1:0] b, input logic [9:0] col,
                      input int kind);
        int t;
        issue(1'b1, 1'b1, 1'b0, 1'b0, g, b, {6'b0, 1'b0, col}, t);
        for (int i = 0; i < BL; i++) wq.push_back('{cyc: t + CWL + i, data: pat(kind, i)});
    endtask

    task automatic simple_cmd(input logic r, input logic c, input logic w, input logic [16:0] a);
        int t;
        issue(1'b1, r, c, w, 2'd0, 2'd0, a, t);
    endtask

    task automatic expect_read(input int t, input int kind, input int nbeats);
        for (int i = 0; i < nbeats; i++) sbq.push_back('{cyc: t + CL + i, data: pat(kind, i)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sbq.delete();
        wq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2;
        rst = 1'b1; cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        bg = '0; ba = '0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_dq_oe", dq_oe, 1'b0);
        check("rst_dq_out", dq_out, 8'h00);
        check("rst_err_state", err_state, 1'b0);
        check("rst_err_burst", err_burst, 1'b0);
        check("rst_mr_seen", mr_seen, 1'b0);

        // Write then read back the same burst; then back-to-back and too-close reads
        simple_cmd(1'b0, 1'b0, 1'b0, 17'h0);
        check("mr_seen", mr_seen, 1'b1);
        act(2'd0, 2'd0, 17'h1234);
        wr(2'd0, 2'd0, 10'h040, 0);
        idle(CWL + BL + 2);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        expect_read(t, 0, BL);
        idle(CL + BL + 2);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        expect_read(t, 0, BL);
        idle(BL - 1);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t2);
        expect_read(t2, 0, BL);
        idle(CL + BL + 2);
        check("b2b_err_burst", err_burst, 1'b0);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        expect_read(t, 0, BL);
        idle(3);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t2);
        check("close_rd_err_burst", err_burst, 1'b1);
        idle(CL + BL + 2);
        check("close_rd_err_state", err_state, 1'b0);
        rd(2'd0, 2'd0, 10'h040, 1'b1, t);
        expect_read(t, 0, BL);
        idle(CL + BL + 2);
        check("a10_err_state", err_state, 1'b0);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        check("rd_after_a10", err_state, 1'b1);
        idle(4);
        check("err_state_sticky", err_state, 1'b1);
        check("sb_drained_1", sbq.size(), 0);

        // Reset clears flags; RD to a never-activated bank
        do_reset();
        check("rst2_err_state", err_state, 1'b0);
        check("rst2_err_burst", err_burst, 1'b0);
        check("rst2_mr_seen", mr_seen, 1'b0);
        rd(2'd3, 2'd3, 10'h010, 1'b0, t);
        check("rd_closed_err", err_state, 1'b1);
        idle(CL + BL + 2);

        // All banks open, precharge all, refresh is legal; refresh with one bank open is not
        do_reset();
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) act(2'(g), 2'(b), 17'(32'h100 + g * 4 + b));
        end
        check("act_all_err", err_state, 1'b0);
        simple_cmd(1'b0, 1'b1, 1'b0, 17'h400);
        simple_cmd(1'b0, 1'b0, 1'b1, 17'h0);
        check("ref_after_prea", err_state, 1'b0);
        act(2'd1, 2'd1, 17'h0055);
        simple_cmd(1'b0, 1'b0, 1'b1, 17'h0);
        check("ref_bank_open", err_state, 1'b1);

        // Flag setup, read-over-write collision, then reset during read beat 3
        do_reset();
        act(2'd0, 2'd0, 17'h1234);
        simple_cmd(1'b0, 1'b0, 1'b0, 17'h0);
        act(2'd0, 2'd0, 17'h1234);
        check("act_open_err", err_state, 1'b1);
        wr(2'd0, 2'd0, 10'h080, 1);
        idle(1);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        check("rd_over_wr", err_burst, 1'b1);
        idle(CWL + BL + 4);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        expect_read(t, 0, 4);
        idle(CL + 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_dq_oe", dq_oe, 1'b0);
        check("midrst_err_state", err_state, 1'b0);
        check("midrst_err_burst", err_burst, 1'b0);
        check("midrst_mr_seen", mr_seen, 1'b0);
        idle(2);
        check("midrst_dq_oe_later", dq_oe, 1'b0);
        rd(2'd0, 2'd0, 10'h040, 1'b0, t);
        check("midrst_bank_closed", err_state, 1'b1);
        idle(CL + BL + 2);

        check("sb_drained_end", sbq.size(), 0);
        check("wq_drained_end", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
